// File: rtl/noc_pkg.sv
// Shared NoC router definitions: default widths, flit type encoding and the
// one-hot port select codes understood by the per-port flit multiplexer.
package noc_pkg;

  localparam int DATA_W = 64;
  localparam int VCH_W  = 2;
  localparam int SEL_W  = 5;

  // Flit type lives in the top two bits of every flit
  localparam logic [1:0] TYPE_NONE = 2'b00;
  localparam logic [1:0] TYPE_HEAD = 2'b01;
  localparam logic [1:0] TYPE_TAIL = 2'b10;
  localparam logic [1:0] TYPE_DATA = 2'b11;

  localparam logic [4:0] SEL_P0 = 5'b00001;
  localparam logic [4:0] SEL_P1 = 5'b00010;

endpackage

// File: rtl/flit_mux_if.sv
// Flit bus of one crossbar output port: two candidate input streams, the
// one-hot select and the registered output stream.
interface flit_mux_if #(
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int VCH_W  = noc_pkg::VCH_W,
  parameter int SEL_W  = noc_pkg::SEL_W
) ();

  logic [DATA_W-1:0] idata_0;
  logic              ivalid_0;
  logic [VCH_W-1:0]  ivch_0;
  logic [DATA_W-1:0] idata_1;
  logic              ivalid_1;
  logic [VCH_W-1:0]  ivch_1;
  logic [SEL_W-1:0]  sel;
  logic [DATA_W-1:0] odata;
  logic              ovalid;
  logic [VCH_W-1:0]  ovch;

  modport master (
    output idata_0, ivalid_0, ivch_0,
    output idata_1, ivalid_1, ivch_1,
    output sel,
    input  odata, ovalid, ovch
  );

  modport slave (
    input  idata_0, ivalid_0, ivch_0,
    input  idata_1, ivalid_1, ivch_1,
    input  sel,
    output odata, ovalid, ovch
  );

endinterface

// File: rtl/flit_mux_sel_onehot.sv
// Combinational one-hot decode and AND-OR select of {valid, vch, data}.
// Any select other than exactly SEL_P0 or SEL_P1 picks nothing and raises none.
module flit_sel_onehot #(
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int VCH_W  = noc_pkg::VCH_W,
  parameter int SEL_W  = noc_pkg::SEL_W
) (
  input  logic [SEL_W-1:0]  sel,
  input  logic [DATA_W-1:0] data_0,
  input  logic              valid_0,
  input  logic [VCH_W-1:0]  vch_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic              valid_1,
  input  logic [VCH_W-1:0]  vch_1,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic [VCH_W-1:0]  vch,
  output logic              none
);
  import noc_pkg::*;

  logic pick_0;
  logic pick_1;

  // Full-width compare so multi-hot and upper-port codes decode to nothing
  assign pick_0 = (sel == SEL_W'(SEL_P0));
  assign pick_1 = (sel == SEL_W'(SEL_P1));
  assign none   = ~(pick_0 | pick_1);

  assign valid = (pick_0 & valid_0) | (pick_1 & valid_1);
  assign vch   = ({VCH_W{pick_0}} & vch_0) | ({VCH_W{pick_1}} & vch_1);
  assign data  = ({DATA_W{pick_0}} & data_0) | ({DATA_W{pick_1}} & data_1);

endmodule

// File: rtl/flit_mux.sv
// Registered two-input flit multiplexer for one NoC crossbar output port.
// Define FLIT_MUX_ACTCNT_EN to add the flit_cnt/toggle_cnt activity counters.
module flit_mux #(
  parameter int DATA_W = noc_pkg::DATA_W,
  parameter int VCH_W  = noc_pkg::VCH_W,
  parameter int SEL_W  = noc_pkg::SEL_W
) (
  input  logic        clk,
  input  logic        rst_,
`ifdef FLIT_MUX_ACTCNT_EN
  output logic [31:0] flit_cnt,
  output logic [31:0] toggle_cnt,
`endif
  flit_mux_if.slave   bus
);
  import noc_pkg::*;

  logic [DATA_W-1:0] sel_data;
  logic              sel_valid;
  logic [VCH_W-1:0]  sel_vch;
  logic              sel_none;
  logic              load;

  logic [DATA_W-1:0] odata_r;
  logic              ovalid_r;
  logic [VCH_W-1:0]  ovch_r;

  flit_sel_onehot #(
    .DATA_W (DATA_W),
    .VCH_W  (VCH_W),
    .SEL_W  (SEL_W)
  ) u_sel (
    .sel     (bus.sel),
    .data_0  (bus.idata_0),
    .valid_0 (bus.ivalid_0),
    .vch_0   (bus.ivch_0),
    .data_1  (bus.idata_1),
    .valid_1 (bus.ivalid_1),
    .vch_1   (bus.ivch_1),
    .data    (sel_data),
    .valid   (sel_valid),
    .vch     (sel_vch),
    .none    (sel_none)
  );

  assign load = sel_valid & ~sel_none;

  // Data and vch only move on a real flit, keeping idle cycles switch-free
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      odata_r  <= '0;
      ovalid_r <= 1'b0;
      ovch_r   <= '0;
    end else begin
      ovalid_r <= load;
      if (load) begin
        odata_r <= sel_data;
        ovch_r  <= sel_vch;
      end
    end
  end

  assign bus.odata  = odata_r;
  assign bus.ovalid = ovalid_r;
  assign bus.ovch   = ovch_r;

`ifdef FLIT_MUX_ACTCNT_EN
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      flit_cnt   <= '0;
      toggle_cnt <= '0;
    end else if (load) begin
      flit_cnt   <= flit_cnt + 32'd1;
      toggle_cnt <= toggle_cnt + 32'($countones(sel_data ^ odata_r));
    end
  end
`endif

endmodule

// File: tb/tb_flit_mux.sv
// Scoreboard bench for flit_mux: directed vectors push expected outputs,
// a monitor pops one entry per clock edge and compares. Covers FLIT_MUX_ACTCNT_EN.
module tb_flit_mux;
  import noc_pkg::*;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
    logic [1:0]  vch;
  } exp_t;

  localparam int SRC_IN0  = 0;
  localparam int SRC_IN1  = 1;
  localparam int SRC_HOLD = 2;

  logic clk  = 1'b0;
  logic rst_ = 1'b0;

  always #5 clk = ~clk;

  flit_mux_if bus ();

`ifdef FLIT_MUX_ACTCNT_EN
  logic [31:0] flit_cnt;
  logic [31:0] toggle_cnt;
`endif

  flit_mux dut (
    .clk        (clk),
    .rst_       (rst_),
`ifdef FLIT_MUX_ACTCNT_EN
    .flit_cnt   (flit_cnt),
    .toggle_cnt (toggle_cnt),
`endif
    .bus        (bus)
  );

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] hold_data = '0;
  logic [1:0]  hold_vch = '0;
  int          exp_flits = 0;
  logic [31:0] exp_toggles = '0;

  task automatic checkOutput(input string name, input exp_t e);
    checks++;
    if (bus.ovalid !== e.valid) begin
      errors++;
      $display("[TB] FAIL %s ovalid got %0b want %0b", name, bus.ovalid, e.valid);
    end
    checks++;
    if (bus.odata !== e.data) begin
      errors++;
      $display("[TB] FAIL %s odata got %h want %h", name, bus.odata, e.data);
    end
    checks++;
    if (bus.ovch !== e.vch) begin
      errors++;
      $display("[TB] FAIL %s ovch got %0d want %0d", name, bus.ovch, e.vch);
    end
  endtask

  // Drives one cycle of inputs; src names which input must appear after the edge
  task automatic applyStimulus(input logic [4:0] s,
                               input logic v0, input logic [63:0] d0, input logic [1:0] c0,
                               input logic v1, input logic [63:0] d1, input logic [1:0] c1,
                               input int src);
    exp_t e;
    bus.sel      = s;
    bus.ivalid_0 = v0;
    bus.idata_0  = d0;
    bus.ivch_0   = c0;
    bus.ivalid_1 = v1;
    bus.idata_1  = d1;
    bus.ivch_1   = c1;
    if (src == SRC_IN0)      e = '{valid: 1'b1, data: d0, vch: c0};
    else if (src == SRC_IN1) e = '{valid: 1'b1, data: d1, vch: c1};
    else                     e = '{valid: 1'b0, data: hold_data, vch: hold_vch};
    if (e.valid) begin
      exp_flits++;
      exp_toggles = exp_toggles + 32'($countones(e.data ^ hold_data));
      hold_data = e.data;
      hold_vch  = e.vch;
    end
    exp_q.push_back(e);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] flitOf(input int i, input int n);
    logic [61:0] payload;
    payload = 62'(i) + 62'h4;
    if (i == 0)      return {TYPE_HEAD, 62'h4};
    if (i == n - 1)  return {TYPE_TAIL, payload};
    return {TYPE_DATA, payload};
  endfunction

  // Asynchronous reset entered mid-cycle, held with toggling inputs
  task automatic doReset(input int cycles);
    exp_t z;
    z = '{valid: 1'b0, data: '0, vch: '0};
    @(negedge clk);
    rst_ = 1'b0;
    hold_data   = '0;
    hold_vch    = '0;
    exp_flits   = 0;
    exp_toggles = '0;
    #1 checkOutput("reset_async", z);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      bus.sel      = (i % 2 == 0) ? SEL_P0 : SEL_P1;
      bus.ivalid_0 = 1'b1;
      bus.idata_0  = rnd64();
      bus.ivch_0   = 2'($urandom);
      bus.ivalid_1 = 1'b1;
      bus.idata_1  = rnd64();
      bus.ivch_1   = 2'($urandom);
      #1 checkOutput("reset_hold", z);
    end
    @(negedge clk);
    bus.sel      = '0;
    bus.ivalid_0 = 1'b0;
    bus.ivalid_1 = 1'b0;
    rst_ = 1'b1;
  endtask

  task automatic sendPacket(input int port, input int n, input logic [1:0] vch);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (port == 0)
        applyStimulus(SEL_P0, 1'b1, flitOf(i, n), vch, 1'b1, rnd64(), 2'($urandom), SRC_IN0);
      else
        applyStimulus(SEL_P1, 1'b1, rnd64(), 2'($urandom), 1'b1, flitOf(i, n), vch, SRC_IN1);
    end
  endtask

  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checkOutput("scoreboard", e);
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog timeout got running want finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.sel      = '0;
    bus.ivalid_0 = 1'b0;
    bus.idata_0  = '0;
    bus.ivch_0   = '0;
    bus.ivalid_1 = 1'b0;
    bus.idata_1  = '0;
    bus.ivch_1   = '0;

    $display("[TB] reset with toggling inputs");
    doReset(3);

    $display("[TB] input 0 valid, vch 2, then drop valid");
    @(negedge clk);
    applyStimulus(SEL_P0, 1'b1, 64'hC0DE_0000_1111_2222, 2'd2,
                  1'b1, 64'h5555_AAAA_5555_AAAA, 2'd1, SRC_IN0);
    @(negedge clk);
    applyStimulus(SEL_P0, 1'b0, 64'h0123_4567_89AB_CDEF, 2'd3,
                  1'b1, 64'hFFFF_0000_FFFF_0000, 2'd1, SRC_HOLD);

    $display("[TB] illegal selects with both inputs valid");
    @(negedge clk);
    applyStimulus(5'b00000, 1'b1, rnd64(), 2'd1, 1'b1, rnd64(), 2'd3, SRC_HOLD);
    @(negedge clk);
    applyStimulus(5'b00011, 1'b1, rnd64(), 2'd1, 1'b1, rnd64(), 2'd3, SRC_HOLD);
    @(negedge clk);
    applyStimulus(5'b00100, 1'b1, rnd64(), 2'd1, 1'b1, rnd64(), 2'd3, SRC_HOLD);

    $display("[TB] 22-flit packet on input 1, noise on input 0");
    sendPacket(1, 22, 2'd1);

    $display("[TB] input 0 packet, 7 idle cycles, input 1 packet");
    sendPacket(0, 5, 2'd3);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      applyStimulus(SEL_P1, 1'b1, rnd64(), 2'd2, 1'b0, rnd64(), 2'd0, SRC_HOLD);
    end
    sendPacket(1, 5, 2'd2);

    $display("[TB] reset in the middle of a packet");
    for (int i = 0; i < 6; i++) begin
      if (i == 3) doReset(2);
      @(negedge clk);
      applyStimulus(SEL_P1, 1'b0, rnd64(), 2'd0, 1'b1, flitOf(i, 6), 2'd1, SRC_IN1);
    end

    $display("[TB] 10 packets of 22 flits");
    doReset(1);
    for (int p = 0; p < 10; p++) sendPacket(p % 2, 22, 2'(p));
    @(negedge clk);
    applyStimulus(5'b00000, 1'b0, '0, '0, 1'b0, '0, '0, SRC_HOLD);
    @(posedge clk);
    #2;

`ifdef FLIT_MUX_ACTCNT_EN
    checks++;
    if (flit_cnt !== 32'd220) begin
      errors++;
      $display("[TB] FAIL flit_cnt got %0d want 220", flit_cnt);
    end
    checks++;
    if (toggle_cnt !== exp_toggles) begin
      errors++;
      $display("[TB] FAIL toggle_cnt got %0d want %0d", toggle_cnt, exp_toggles);
    end
`endif

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d entries want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
